// File: rtl/acc_pkg.sv
// acc_pkg: shared state encoding and constants for the accumulator trigger sequencer
package acc_pkg;
    typedef enum logic [2:0] {S_IDLE, S_FIRE, S_WAIT, S_FLUSH, S_DRAIN} state_t;
    localparam int GUARD_DEF = 16;
    localparam int SHIFT_W = 16;
endpackage

// File: rtl/acc_pri_timer.sv
// acc_pri_timer: reloadable down-counter that ticks once every latched period
module acc_pri_timer #(
    parameter int PRI_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clr,
    input  logic [PRI_W-1:0] period,
    output logic             tick
);
    logic [PRI_W-1:0] cnt_q, cnt_d, per_q, per_d;
    logic             run_q, run_d;

    assign tick = run_q && cnt_q == '0;

    // load restarts the count from the new period; each tick reloads from the latched one
    always_comb begin
        per_d = load ? period : per_q;
        run_d = clr ? 1'b0 : (load ? 1'b1 : run_q);
        cnt_d = clr ? '0 : load ? period - 1'b1 : tick ? per_q - 1'b1 : run_q ? cnt_q - 1'b1 : cnt_q;
    end

    // counter state
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            per_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            per_q <= per_d;
            run_q <= run_d;
        end
    end
endmodule

// File: rtl/acc_trig_sched.sv
// acc_trig_sched: trig/trig_int pulse sequencer and frame-completion counter for the pulse accumulator
module acc_trig_sched
    import acc_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int GUARD = GUARD_DEF,
    parameter int PRI_W = 24,
    parameter int FRM_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               abort,
    input  logic [PRI_W-1:0]   cfg_pri,
    input  logic [3:0]         cfg_log2_count,
    input  logic [FRM_W-1:0]   cfg_frames,
    input  logic               acc_vld,
    output logic               trig,
    output logic               trig_int,
    output logic [SHIFT_W-1:0] shift,
    output logic               busy,
    output logic               frame_done,
    output logic               cfg_err
);
    localparam int SW = $clog2(DEPTH + 1);

    state_t             st_q, st_d;
    logic [SHIFT_W-1:0] p_q, p_d, mask;
    logic [FRM_W-1:0]   f_q, f_d, frames_q, frames_d;
    logic [3:0]         l_q, l_d;
    logic [SW-1:0]      s_q, s_d;
    logic stop_q, stop_d, trig_q, trig_d, ti_q, ti_d, busy_q, busy_d, fd_q, fd_d, err_q, err_d;
    logic tick, tclr, go, accept, reject, vld_end, end_run;

    assign go      = st_q == S_IDLE && start && !abort;
    assign accept  = go && cfg_pri >= PRI_W'(DEPTH + GUARD);
    assign reject  = go && !accept;
    assign mask    = {SHIFT_W{1'b1}} >> (5'(SHIFT_W) - {1'b0, l_q});
    assign vld_end = busy_q && acc_vld && s_q == SW'(DEPTH - 1);
    assign end_run = stop_q || stop || (frames_q != '0 && f_q + 1'b1 == frames_q);

    acc_pri_timer #(.PRI_W(PRI_W)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .clr   (tclr),
        .period(cfg_pri),
        .tick  (tick)
    );

    // sequencing: a pulse is issued on each timer tick; the wrap pulse either opens a new frame or becomes the flush
    always_comb begin
        st_d     = st_q;
        p_d      = p_q;
        f_d      = f_q;
        frames_d = frames_q;
        l_d      = l_q;
        stop_d   = stop_q;
        s_d      = busy_q && acc_vld ? (vld_end ? '0 : s_q + 1'b1) : s_q;
        trig_d   = 1'b0;
        ti_d     = 1'b0;
        busy_d   = busy_q;
        fd_d     = vld_end;
        err_d    = err_q;
        tclr     = 1'b0;
        if (abort && busy_q) begin
            st_d   = S_IDLE;
            busy_d = 1'b0;
            s_d    = '0;
            fd_d   = 1'b0;
            stop_d = 1'b0;
            tclr   = 1'b1;
        end else begin
            case (st_q)
                S_IDLE: begin
                    err_d = reject || (err_q && !accept);
                    if (accept) begin
                        st_d     = S_FIRE;
                        trig_d   = 1'b1;
                        ti_d     = 1'b1;
                        busy_d   = 1'b1;
                        p_d      = '0;
                        f_d      = '0;
                        s_d      = '0;
                        stop_d   = 1'b0;
                        frames_d = cfg_frames;
                        l_d      = cfg_log2_count;
                    end
                end
                S_FIRE, S_WAIT: begin
                    st_d   = S_WAIT;
                    stop_d = stop_q || stop;
                    if (tick) begin
                        trig_d = 1'b1;
                        ti_d   = p_q == mask;
                        if (p_q != mask) begin
                            st_d = S_FIRE;
                            p_d  = p_q + 1'b1;
                        end else if (end_run) begin
                            st_d = S_FLUSH;
                            tclr = 1'b1;
                        end else begin
                            st_d = S_FIRE;
                            p_d  = '0;
                            f_d  = f_q + 1'b1;
                        end
                    end
                end
                S_FLUSH: st_d = S_DRAIN;
                S_DRAIN: begin
                    st_d   = vld_end ? S_IDLE : S_DRAIN;
                    busy_d = !vld_end;
                end
                default: st_d = S_IDLE;
            endcase
        end
    end

    // state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q     <= S_IDLE;
            p_q      <= '0;
            f_q      <= '0;
            frames_q <= '0;
            l_q      <= '0;
            s_q      <= '0;
            stop_q   <= 1'b0;
            trig_q   <= 1'b0;
            ti_q     <= 1'b0;
            busy_q   <= 1'b0;
            fd_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            st_q     <= st_d;
            p_q      <= p_d;
            f_q      <= f_d;
            frames_q <= frames_d;
            l_q      <= l_d;
            s_q      <= s_d;
            stop_q   <= stop_d;
            trig_q   <= trig_d;
            ti_q     <= ti_d;
            busy_q   <= busy_d;
            fd_q     <= fd_d;
            err_q    <= err_d;
        end
    end

    assign trig       = trig_q;
    assign trig_int   = ti_q;
    assign shift      = SHIFT_W'(l_q);
    assign busy       = busy_q;
    assign frame_done = fd_q;
    assign cfg_err    = err_q;
endmodule
